// File: rtl/fft_frame_src.sv
// rtl/fft_frame_src.sv - decimating ADC capture feeding one FFT frame per start
// Offset-binary samples are converted and queued in a skid FIFO whose head is registered.
module fft_frame_src #(
  parameter int         FFT_LEN    = 4096,
  parameter int         DECIM      = 8,
  parameter int         FIFO_DEPTH = 16,
  parameter logic [7:0] CFG_WORD   = 8'd1
) (
  input  logic        fft_clk,
  input  logic        rst,
  input  logic [9:0]  ad_data,
  input  logic        ad_valid,
  input  logic        start,
  output logic [7:0]  cfg_tdata,
  output logic        cfg_tvalid,
  input  logic        cfg_tready,
  output logic [31:0] data_tdata,
  output logic        data_tvalid,
  input  logic        data_tready,
  output logic        data_tlast,
  output logic        busy,
  output logic        frame_done,
  output logic        overflow
);

  localparam int CNT_W = $clog2(FFT_LEN) + 1;
  localparam int DEC_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FW    = AW + 1;

  localparam logic [CNT_W-1:0] LEN      = CNT_W'(FFT_LEN);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FFT_LEN - 1);
  localparam logic [DEC_W-1:0] DEC_MAX  = DEC_W'(DECIM - 1);
  localparam logic [FW-1:0]    DEPTH    = FW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_CFG, S_STREAM, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [DEC_W-1:0] dec_cnt_q, dec_cnt_d;
  logic [CNT_W-1:0] cap_cnt_q, cap_cnt_d;
  logic [CNT_W-1:0] send_cnt_q, send_cnt_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [15:0]      mem_q [FIFO_DEPTH];
  logic [15:0]      head_q, head_d;
  logic             tvalid_q, tvalid_d;
  logic             tlast_q, tlast_d;
  logic             cfg_tvalid_q, cfg_tvalid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;

  logic [15:0]      sample_real;
  logic [AW-1:0]    rd_next;
  logic             fifo_full;
  logic             keep;
  logic             push;
  logic             pop;

  // Inverting the MSB of offset binary gives two's complement; then sign-extend.
  assign sample_real = {{6{~ad_data[9]}}, ~ad_data[9], ad_data[8:0]};
  assign rd_next     = rd_ptr_q + 1'b1;
  assign fifo_full   = (fill_q == DEPTH);

  always_comb begin
    state_d    = state_q;
    dec_cnt_d  = dec_cnt_q;
    cap_cnt_d  = cap_cnt_q;
    send_cnt_d = send_cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fill_d     = fill_q;
    head_d     = head_q;
    ovf_d      = ovf_q;
    keep       = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;

    case (state_q)
      S_IDLE: begin
        dec_cnt_d  = '0;
        cap_cnt_d  = '0;
        send_cnt_d = '0;
        wr_ptr_d   = '0;
        rd_ptr_d   = '0;
        fill_d     = '0;
        head_d     = '0;
        // Overflow survives the idle gap so it can be read after frame_done.
        if (start) begin
          state_d = S_CFG;
          ovf_d   = 1'b0;
        end
      end

      S_CFG: begin
        if (cfg_tvalid_q && cfg_tready) begin
          state_d = S_STREAM;
        end
      end

      S_STREAM: begin
        pop = tvalid_q && data_tready;
        if (ad_valid) begin
          dec_cnt_d = (dec_cnt_q == DEC_MAX) ? '0 : dec_cnt_q + 1'b1;
          keep      = (dec_cnt_q == '0) && (cap_cnt_q < LEN);
        end
        if (keep) begin
          if (!fifo_full || pop) begin
            push = 1'b1;
          end else begin
            ovf_d = 1'b1;
          end
        end
        if (push) begin
          wr_ptr_d  = wr_ptr_q + 1'b1;
          cap_cnt_d = cap_cnt_q + 1'b1;
        end
        if (pop) begin
          rd_ptr_d   = rd_next;
          send_cnt_d = send_cnt_q + 1'b1;
          if (send_cnt_q == LAST_IDX) begin
            state_d = S_DONE;
          end
        end
        fill_d = fill_q + FW'(push) - FW'(pop);
        // Head register only moves on a pop or when filling an empty FIFO.
        if (pop) begin
          if (fill_q > FW'(1)) begin
            head_d = mem_q[rd_next];
          end else if (push) begin
            head_d = sample_real;
          end
        end else if ((fill_q == '0) && push) begin
          head_d = sample_real;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    cfg_tvalid_d = (state_d == S_CFG);
    busy_d       = (state_d != S_IDLE);
    done_d       = (state_d == S_DONE);
    tvalid_d     = (fill_d != '0);
    tlast_d      = (fill_d != '0) && (send_cnt_d == LAST_IDX);
  end

  always_ff @(posedge fft_clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      dec_cnt_q    <= '0;
      cap_cnt_q    <= '0;
      send_cnt_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fill_q       <= '0;
      head_q       <= '0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      cfg_tvalid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      dec_cnt_q    <= dec_cnt_d;
      cap_cnt_q    <= cap_cnt_d;
      send_cnt_q   <= send_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fill_q       <= fill_d;
      head_q       <= head_d;
      tvalid_q     <= tvalid_d;
      tlast_q      <= tlast_d;
      cfg_tvalid_q <= cfg_tvalid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      ovf_q        <= ovf_d;
    end
  end

  always_ff @(posedge fft_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= sample_real;
    end
  end

  assign cfg_tdata   = CFG_WORD;
  assign cfg_tvalid  = cfg_tvalid_q;
  assign data_tdata  = {16'h0000, head_q};
  assign data_tvalid = tvalid_q;
  assign data_tlast  = tlast_q;
  assign busy        = busy_q;
  assign frame_done  = done_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_fft_frame_src.sv
// tb/tb_fft_frame_src.sv - self-checking bench for fft_frame_src
module tb_fft_frame_src;

  localparam int LA = 32;
  localparam int LD = 16;
  localparam int DD = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  ad_data;
  logic        ad_valid, start_a, start_d, cfg_tready, data_tready;

  logic [7:0]  cfg_tdata_a, cfg_tdata_d;
  logic        cfg_tvalid_a, cfg_tvalid_d;
  logic [31:0] data_tdata_a, data_tdata_d;
  logic        data_tvalid_a, data_tvalid_d, data_tlast_a, data_tlast_d;
  logic        busy_a, busy_d, frame_done_a, frame_done_d, overflow_a, overflow_d;

  always #5 clk = ~clk;

  fft_frame_src #(.FFT_LEN(LA), .DECIM(1), .FIFO_DEPTH(16), .CFG_WORD(8'd1)) u_a (
    .fft_clk(clk), .rst(rst), .ad_data(ad_data), .ad_valid(ad_valid), .start(start_a),
    .cfg_tdata(cfg_tdata_a), .cfg_tvalid(cfg_tvalid_a), .cfg_tready(cfg_tready),
    .data_tdata(data_tdata_a), .data_tvalid(data_tvalid_a), .data_tready(data_tready),
    .data_tlast(data_tlast_a), .busy(busy_a), .frame_done(frame_done_a), .overflow(overflow_a));

  fft_frame_src #(.FFT_LEN(LD), .DECIM(DD), .FIFO_DEPTH(16), .CFG_WORD(8'd1)) u_d (
    .fft_clk(clk), .rst(rst), .ad_data(ad_data), .ad_valid(ad_valid), .start(start_d),
    .cfg_tdata(cfg_tdata_d), .cfg_tvalid(cfg_tvalid_d), .cfg_tready(cfg_tready),
    .data_tdata(data_tdata_d), .data_tvalid(data_tvalid_d), .data_tready(data_tready),
    .data_tlast(data_tlast_d), .busy(busy_d), .frame_done(frame_done_d), .overflow(overflow_d));

  typedef struct {
    logic [31:0] data;
    logic        last;
    int          cyc;
  } beat_t;

  typedef struct {
    logic [9:0]  ad;
    logic [15:0] re;
  } conv_vec_t;

  conv_vec_t   tbl [6];
  beat_t       beats_a[$];
  beat_t       beats_d[$];
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  int          stab_err_a = 0;
  logic        prev_stall_a = 1'b0;
  logic [31:0] prev_data_a = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (data_tvalid_a && data_tready) beats_a.push_back('{data_tdata_a, data_tlast_a, cyc});
    if (data_tvalid_d && data_tready) beats_d.push_back('{data_tdata_d, data_tlast_d, cyc});
    if (prev_stall_a && (!data_tvalid_a || data_tdata_a != prev_data_a)) stab_err_a++;
    prev_stall_a = data_tvalid_a && !data_tready && !rst;
    prev_data_a  = data_tdata_a;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference conversion: offset binary minus mid-scale.
  function automatic logic [15:0] conv(input logic [9:0] ad);
    return 16'(int'(ad) - 512);
  endfunction

  task automatic chk_reset_a(input string tag);
    chk({tag, "_cfg_tdata"}, 32'(cfg_tdata_a), 32'h1);
    chk({tag, "_cfg_tvalid"}, 32'(cfg_tvalid_a), 0);
    chk({tag, "_data_tdata"}, data_tdata_a, 0);
    chk({tag, "_data_tvalid"}, 32'(data_tvalid_a), 0);
    chk({tag, "_data_tlast"}, 32'(data_tlast_a), 0);
    chk({tag, "_busy"}, 32'(busy_a), 0);
    chk({tag, "_frame_done"}, 32'(frame_done_a), 0);
    chk({tag, "_overflow"}, 32'(overflow_a), 0);
  endtask

  task automatic wait_done_a(input int max, output int dcyc);
    dcyc = -1;
    for (int i = 0; i < max; i++) begin
      if (frame_done_a) begin
        dcyc = cyc;
        break;
      end
      tick();
    end
    if (dcyc < 0) chk("frame_done_timeout_a", 0, 1);
  endtask

  task automatic compare_a(input string tag, input logic [15:0] exp[$]);
    int n;
    chk({tag, "_beat_count"}, 32'(beats_a.size()), 32'(exp.size()));
    n = (beats_a.size() < exp.size()) ? beats_a.size() : exp.size();
    for (int j = 0; j < n; j++) begin
      chk($sformatf("%s_beat%0d_data", tag, j), beats_a[j].data, {16'h0000, exp[j]});
      chk($sformatf("%s_beat%0d_tlast", tag, j), 32'(beats_a[j].last), 32'(j == exp.size() - 1));
    end
  endtask

  task automatic start_a_frame();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("start_busy", 32'(busy_a), 1);
    chk("start_cfg_tvalid", 32'(cfg_tvalid_a), 1);
    chk("start_clr_overflow", 32'(overflow_a), 0);
    tick();
    chk("cfg_hold_tvalid", 32'(cfg_tvalid_a), 1);
    // A sample strobed in the handshake cycle itself must not be captured.
    cfg_tready = 1'b1;
    ad_valid   = 1'b1;
    ad_data    = 10'h155;
    tick();
    cfg_tready = 1'b0;
    ad_valid   = 1'b0;
    chk("cfg_tvalid_drop", 32'(cfg_tvalid_a), 0);
    chk("no_handshake_sample", 32'(data_tvalid_a), 0);
  endtask

  task automatic run_ramp_frame(input string tag);
    logic [15:0] exp[$];
    int dcyc;
    beats_a.delete();
    start_a_frame();
    data_tready = 1'b1;
    for (int i = 0; i < LA; i++) begin
      ad_valid = 1'b1;
      ad_data  = (i < 6) ? tbl[i].ad : 10'(i);
      exp.push_back((i < 6) ? tbl[i].re : conv(10'(i)));
      if (i == 10) start_a = 1'b1;
      if (i == 0) chk({tag, "_tvalid_before_first"}, 32'(data_tvalid_a), 0);
      tick();
      start_a = 1'b0;
      if (i == 0) chk({tag, "_tvalid_after_first"}, 32'(data_tvalid_a), 1);
    end
    ad_valid = 1'b0;
    wait_done_a(100, dcyc);
    compare_a(tag, exp);
    if (dcyc >= 0 && beats_a.size() > 0) begin
      chk({tag, "_done_latency"}, 32'(dcyc), 32'(beats_a[beats_a.size()-1].cyc + 1));
      chk({tag, "_busy_at_done"}, 32'(busy_a), 1);
      tick();
      chk({tag, "_done_pulse"}, 32'(frame_done_a), 0);
      chk({tag, "_busy_after"}, 32'(busy_a), 0);
      chk({tag, "_overflow"}, 32'(overflow_a), 0);
      tick();
      tick();
      chk({tag, "_no_queued_start"}, 32'(busy_a | cfg_tvalid_a), 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] exp[$];
    int dcyc, n;

    tbl[0] = '{10'h000, 16'hFE00};
    tbl[1] = '{10'h200, 16'h0000};
    tbl[2] = '{10'h3FF, 16'h01FF};
    tbl[3] = '{10'h001, 16'hFE01};
    tbl[4] = '{10'h1FF, 16'hFFFF};
    tbl[5] = '{10'h201, 16'h0001};

    rst = 1'b1; ad_data = '0; ad_valid = 1'b0; start_a = 1'b0; start_d = 1'b0;
    cfg_tready = 1'b0; data_tready = 1'b0;
    tick(); tick(); tick();
    chk_reset_a("reset");
    chk("reset_d_busy", 32'(busy_d), 0);
    chk("reset_d_tvalid", 32'(data_tvalid_d), 0);
    rst = 1'b0;
    tick();

    // Handshake, conversion table and ignored start while busy.
    run_ramp_frame("ramp");

    // Random backpressure, sparse input.
    beats_a.delete();
    exp.delete();
    stab_err_a = 0;
    start_a_frame();
    n = 0;
    for (int i = 0; i < 2000 && !frame_done_a; i++) begin
      data_tready = 1'($urandom % 2);
      if (i % 4 == 0 && n < LA) begin
        ad_valid = 1'b1;
        ad_data  = 10'($urandom);
        exp.push_back(conv(ad_data));
        n++;
      end else begin
        ad_valid = 1'b0;
      end
      tick();
    end
    ad_valid = 1'b0;
    chk("bp_frame_done", 32'(frame_done_a), 1);
    compare_a("bp", exp);
    chk("bp_tdata_stable", 32'(stab_err_a), 0);
    chk("bp_overflow", 32'(overflow_a), 0);
    data_tready = 1'b1;
    tick(); tick();

    // Overflow: sink stalled for 40 samples, FIFO holds 16.
    beats_a.delete();
    exp.delete();
    stab_err_a = 0;
    start_a_frame();
    for (int i = 0; i < 200 && !frame_done_a; i++) begin
      ad_valid    = 1'b1;
      ad_data     = 10'(i);
      data_tready = (i >= 40);
      tick();
      if (i == 15) chk("ovf_before_17th", 32'(overflow_a), 0);
      if (i == 16) chk("ovf_on_17th", 32'(overflow_a), 1);
    end
    ad_valid = 1'b0;
    for (int j = 0; j < LA; j++) exp.push_back(conv(10'((j < 16) ? j : 40 + j - 16)));
    chk("ovf_frame_done", 32'(frame_done_a), 1);
    compare_a("ovf", exp);
    chk("ovf_tdata_stable", 32'(stab_err_a), 0);
    tick(); tick(); tick();
    chk("ovf_sticky_after_frame", 32'(overflow_a), 1);

    // Reset mid-stream, then a clean frame.
    start_a_frame();
    data_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ad_valid = 1'b1;
      ad_data  = 10'(i + 100);
      tick();
    end
    ad_valid = 1'b0;
    chk("pre_rst_tvalid", 32'(data_tvalid_a), 1);
    rst = 1'b1;
    tick();
    chk_reset_a("mid_rst");
    rst = 1'b0;
    tick();
    run_ramp_frame("after_rst");

    // Decimation by 8 on the second instance.
    beats_d.delete();
    start_d = 1'b1;
    tick();
    start_d = 1'b0;
    chk("dec_busy", 32'(busy_d), 1);
    cfg_tready = 1'b1;
    ad_valid   = 1'b1;
    ad_data    = 10'h3FF;
    tick();
    cfg_tready  = 1'b0;
    data_tready = 1'b1;
    for (int idx = 0; idx < LD * DD + 40 && !frame_done_d; idx++) begin
      ad_valid = 1'b1;
      ad_data  = 10'(idx);
      tick();
    end
    ad_valid = 1'b0;
    chk("dec_frame_done", 32'(frame_done_d), 1);
    chk("dec_beat_count", 32'(beats_d.size()), LD);
    for (int j = 0; j < LD && j < beats_d.size(); j++) begin
      chk($sformatf("dec_beat%0d_data", j), beats_d[j].data, {16'h0000, conv(10'(j * DD))});
      chk($sformatf("dec_beat%0d_tlast", j), 32'(beats_d[j].last), 32'(j == LD - 1));
    end
    tick();
    chk("dec_busy_after", 32'(busy_d), 0);
    chk("dec_overflow", 32'(overflow_d), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
